// File: rtl/fw_meter.sv
// fw_meter: recovers a DDFS tuning word by counting rising edges of the
// sample MSB over a gate window of exactly 2^N clock cycles.
module fw_meter #(
   parameter int N = 10,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [M-1:0] sine,
   input  logic         start,
   input  logic         ack,
   input  logic         cont,
   output logic [N-1:0] fw_est,
   output logic         valid,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
   localparam logic [N:0] GLAST = {1'b0, {N{1'b1}}};
   state_t state;
   logic s_q, s_prev, rise;
   logic [N:0] gcnt;
   logic [N-1:0] ecnt, ecnt_nxt;
   assign rise = s_q & ~s_prev;
   // saturate so the count can never wrap back through zero
   assign ecnt_nxt = (rise && ecnt != {N{1'b1}}) ? ecnt + N'(1) : ecnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         s_q    <= 1'b0;
         s_prev <= 1'b0;
         gcnt   <= '0;
         ecnt   <= '0;
         fw_est <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         s_q    <= sine[M-1];
         s_prev <= s_q;
         case (state)
            IDLE: if (start) begin
               state <= ARM;
               busy  <= 1'b1;
            end
            ARM: begin
               ecnt  <= '0;
               gcnt  <= '0;
               state <= GATE;
            end
            GATE: begin
               gcnt <= gcnt + (N+1)'(1);
               ecnt <= ecnt_nxt;
               // the final window edge is folded straight into the result
               if (gcnt == GLAST) begin
                  state  <= DONE;
                  fw_est <= ecnt_nxt;
                  valid  <= 1'b1;
                  busy   <= 1'b0;
               end
            end
            DONE: if (cont || (ack && start)) begin
               state <= ARM;
               valid <= 1'b0;
               busy  <= 1'b1;
            end else if (ack) begin
               state <= IDLE;
               valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fw_meter.md
# fw_meter

Frequency-word meter for the DDFS output path: receives the M-bit square/sine sample stream that `clk_div` produces and recovers the tuning word `fw` that generated it. It counts rising edges of the sample MSB over a gate window of exactly 2^N clock cycles; that count equals `fw` exactly. The block sits beside the synthesiser as a self-check and loop-back monitor, and is clocked by the same `clk`.

## Interface
- `N`, 10: phase-accumulator width; the gate window is 2^N cycles and `fw_est` is N bits.
- `M`, 4: width of the incoming sample bus.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sine`  in  M  DDFS sample; only `sine[M-1]` is used.
- `start`  in  1  request a measurement; sampled only in IDLE, and in DONE together with `ack`.
- `ack`  in  1  consumer has read `fw_est`; sampled only in DONE.
- `cont`  in  1  continuous mode; sampled in DONE.
- `fw_est`  out  N  measured tuning word; registered; holds its last value until the next DONE.
- `valid`  out  1  high while in DONE.
- `busy`  out  1  high in ARM and GATE.

## Operation
- Input stage: `s_q <= sine[M-1]` and `s_prev <= s_q` every cycle. `edge = s_q & ~s_prev`.
- Gate counter `gcnt`: N+1 bits. Edge counter `ecnt`: N bits, saturating at 2^N-1.
- States: IDLE, ARM, GATE, DONE.
- IDLE:
  - `start=1` moves to ARM; otherwise stay in IDLE.
- ARM (1 cycle):
  - Clear `ecnt` and `gcnt`.
  - `s_prev` loads normally, so a level already present is not counted as an edge.
  - Next state: GATE.
- GATE:
  - Each cycle: `gcnt += 1`, and `ecnt += edge`.
  - On the cycle where `gcnt == 2^N-1`, the edge is still counted and the next state is DONE.
  - Exactly 2^N samples are evaluated.
- DONE:
  - On entry (the transition cycle), `fw_est <= ecnt`.
  - `cont=1`: go to ARM next cycle, so `valid` is a 1-cycle pulse.
  - Else `ack=1`: go to IDLE, or to ARM if `start=1` in the same cycle.
  - Else stay in DONE.
- Result rules:
  - For 0 ≤ fw ≤ 2^(N-1), `fw_est == fw` exactly, because the phase advance over 2^N samples is fw·2^N, i.e. fw whole wraps of the MSB threshold.
  - For fw > 2^(N-1), the result aliases to 2^N - fw. No flag is raised; this is the documented Nyquist limit.
- `start` while `busy` is ignored. `ack` outside DONE is ignored.
- Mid-measurement changes of `fw` are legal. The result is the edge count in the window, with no averaging.

## Timing
- Reset values (any state): IDLE; `fw_est=0`, `valid=0`, `busy=0`; `gcnt=0`, `ecnt=0`; `s_q=0`, `s_prev=0`.
- Reset mid-GATE aborts the measurement. No `valid` is produced, and `fw_est` returns to 0.
- Measurement cycle, with `start` sampled high at edge t:
  - ARM during t+1.
  - GATE during t+2 … t+2^N+1.
  - DONE during t+2^N+2, with `valid=1` and the new `fw_est` visible in the same cycle.
- Pipeline offset: the sample sequence evaluated is `sine[M-1]` as presented at edges t … t+2^N+1. This covers the 2-cycle input pipe.
- Continuous mode period: 2^N+2 cycles per result.
- `ack` and `start` together in DONE: `valid` drops next cycle and ARM is entered. There is no idle cycle.

## Test plan
- Reset then `start` with `clk_div` at fw=100 (N=10, M=4) -> `busy` high for 1025 cycles; `valid` rises exactly 1026 cycles after `start`; `fw_est=100`.
- Sweep fw = 0, 1, 511, 512 -> `fw_est` = 0, 1, 511, 512. Then fw=700 -> `fw_est=324` (alias).
- `cont=1` at fw=37 -> `valid` pulses every 1026 cycles, each with `fw_est=37`. Change fw to 38 mid-window -> the next-but-one result is 38.
- Assert `rst` at GATE cycle 500 -> next cycle: IDLE, `busy=0`, `valid=0`, `fw_est=0`. A new `start` gives a correct result.
- `start` pulsed during GATE -> ignored; exactly one result. In DONE, drive `ack=1` and `start=1` together -> `valid=0` next cycle and ARM entered.
- Hold `sine[M-1]=1` before and through ARM, with fw=0 -> `fw_est=0`, confirming no spurious edge is counted at window start.
